// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc_pkg
//  Purpose  : Shared types, widths and instruction field positions for the
//             8-thread barrel-scheduled RISC core.
//  Revision : 1.0 - initial release
// ============================================================================
package risc_pkg;

    localparam int PC_WIDTH           = 8;
    localparam int INSTR_WIDTH        = 32;
    localparam int THREAD_INDEX_BITS  = 3;
    localparam int IMMEDIATE_WIDTH    = 16;
    localparam int DATA_WIDTH         = 64;
    localparam int REG_INDEX_BITS     = 5;
    localparam int DATA_MEM_ADDR_BITS = 8;

    // Instruction field bit positions; bits [31:27] carry no meaning.
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 5;
    localparam int RD_LSB     = 6;
    localparam int RD_MSB     = 10;
    localparam int IMM_LSB    = 11;
    localparam int IMM_MSB    = 26;

    typedef enum logic [5:0] {
        OP_NOP = 6'd0,
        OP_INC = 6'd1,
        OP_LW  = 6'd2,
        OP_SW  = 6'd3
    } opcode_e;

    // One pipeline slot as it travels from EX to WB.
    typedef struct packed {
        logic                         valid;
        logic [THREAD_INDEX_BITS-1:0] tid;
        opcode_e                      opcode;
        logic [REG_INDEX_BITS-1:0]    rd;
        logic [IMMEDIATE_WIDTH-1:0]   imm;
        logic [DATA_WIDTH-1:0]        data;
    } stage_t;

    // Unknown opcodes collapse to NOP so downstream stages only see legal values.
    function automatic opcode_e decode_opcode(input logic [5:0] raw);
        case (raw)
            6'd1:    return OP_INC;
            6'd2:    return OP_LW;
            6'd3:    return OP_SW;
            default: return OP_NOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc_thread_pc_file.sv
`default_nettype none
// ============================================================================
//  Module   : risc_thread_pc_file
//  Purpose  : Round-robin thread counter plus one program counter per thread.
//             Presents the current thread and its PC, and advances both.
//  Revision : 1.0 - initial release
// ============================================================================
module risc_thread_pc_file #(
    parameter int PC_WIDTH          = 8,
    parameter int THREAD_INDEX_BITS = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [THREAD_INDEX_BITS-1:0] tid,
    output logic [PC_WIDTH-1:0]          pc
);

    localparam int NUM_THREADS = 1 << THREAD_INDEX_BITS;

    logic [THREAD_INDEX_BITS-1:0] tid_q;
    logic [PC_WIDTH-1:0]          pc_regs [NUM_THREADS];

    // Step to the next thread every cycle and bump the PC of the thread just fetched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tid_q <= '0;
            for (int i = 0; i < NUM_THREADS; i++) begin
                pc_regs[i] <= '0;
            end
        end else begin
            tid_q          <= tid_q + 1'b1;
            pc_regs[tid_q] <= pc_regs[tid_q] + 1'b1;
        end
    end

    assign tid = tid_q;
    assign pc  = pc_regs[tid_q];

endmodule
`default_nettype wire

// File: rtl/risc_processor.sv
`default_nettype none
// ============================================================================
//  Module   : risc_processor
//  Purpose  : 8-thread barrel-scheduled 5-stage (IF/ID/EX/MEM/WB) RISC core
//             with external 1-cycle-latency instruction, register and data
//             memories. Every external address carries the thread ID on top.
//  Revision : 1.0 - initial release
// ============================================================================
module risc_processor #(
    parameter int PC_WIDTH           = 8,
    parameter int INSTR_WIDTH        = 32,
    parameter int THREAD_INDEX_BITS  = 3,
    parameter int IMMEDIATE_WIDTH    = 16,
    parameter int DATA_WIDTH         = 64,
    parameter int REG_INDEX_BITS     = 5,
    parameter int DATA_MEM_ADDR_BITS = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    output logic [THREAD_INDEX_BITS+PC_WIDTH-1:0]           instr_mem_pc,
    input  logic [INSTR_WIDTH-1:0]                          instr_mem_instruction,
    output logic [THREAD_INDEX_BITS+REG_INDEX_BITS-1:0]     reg_access_raddr,
    input  logic [DATA_WIDTH-1:0]                           reg_access_rdata,
    output logic [THREAD_INDEX_BITS+REG_INDEX_BITS-1:0]     reg_access_waddr,
    output logic [DATA_WIDTH-1:0]                           reg_access_wdata,
    output logic                                            reg_access_we,
    output logic [THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS-1:0] data_mem_raddr,
    input  logic [DATA_WIDTH-1:0]                           data_mem_rdata,
    output logic [THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS-1:0] data_mem_waddr,
    output logic [DATA_WIDTH-1:0]                           data_mem_wdata,
    output logic                                            data_mem_we
);

    import risc_pkg::*;

    // ---------------- IF: thread scheduler and per-thread PCs ----------------
    logic [THREAD_INDEX_BITS-1:0] fetch_tid;
    logic [PC_WIDTH-1:0]          fetch_pc;

    risc_thread_pc_file #(
        .PC_WIDTH          (PC_WIDTH),
        .THREAD_INDEX_BITS (THREAD_INDEX_BITS)
    ) u_pc_file (
        .clk   (clk),
        .reset (reset),
        .tid   (fetch_tid),
        .pc    (fetch_pc)
    );

    assign instr_mem_pc = {fetch_tid, fetch_pc};

    // ---------------- ID: instruction arrives, register read issued ----------
    logic                         id_valid;
    logic [THREAD_INDEX_BITS-1:0] id_tid;
    logic [5:0]                   id_op_raw;
    logic [REG_INDEX_BITS-1:0]    id_rd;
    logic [IMMEDIATE_WIDTH-1:0]   id_imm;

    // Track which thread's fetch is returning; every post-reset fetch is a real slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid <= 1'b0;
            id_tid   <= '0;
        end else begin
            id_valid <= 1'b1;
            id_tid   <= fetch_tid;
        end
    end

    assign id_op_raw        = instr_mem_instruction[OPCODE_MSB:OPCODE_LSB];
    assign id_rd            = instr_mem_instruction[RD_MSB:RD_LSB];
    assign id_imm           = instr_mem_instruction[IMM_MSB:IMM_LSB];
    assign reg_access_raddr = id_valid ? {id_tid, id_rd} : '0;

    // ---------------- EX / MEM / WB pipeline registers ------------------------
    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;

    logic                                        ex_is_inc;
    logic                                        ex_is_lw;
    logic                                        ex_is_sw;
    logic [THREAD_INDEX_BITS+DATA_MEM_ADDR_BITS-1:0] ex_daddr;
    logic [DATA_WIDTH-1:0]                       ex_sum;
    logic                                        wb_writes;

    assign ex_is_inc = ex_q.valid && (ex_q.opcode == OP_INC);
    assign ex_is_lw  = ex_q.valid && (ex_q.opcode == OP_LW);
    assign ex_is_sw  = ex_q.valid && (ex_q.opcode == OP_SW);
    assign ex_daddr  = {ex_q.tid, ex_q.imm[DATA_MEM_ADDR_BITS-1:0]};
    assign ex_sum    = reg_access_rdata + {{(DATA_WIDTH-IMMEDIATE_WIDTH){1'b0}}, ex_q.imm};

    // Loads and stores talk to data memory straight out of EX; idle ports sit at 0.
    assign data_mem_raddr = ex_is_lw ? ex_daddr : '0;
    assign data_mem_waddr = ex_is_sw ? ex_daddr : '0;
    assign data_mem_wdata = ex_is_sw ? reg_access_rdata : '0;
    assign data_mem_we    = ex_is_sw;

    // Advance slots ID->EX->MEM->WB; INC result latched leaving EX, load data leaving MEM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q.valid  <= id_valid;
            ex_q.tid    <= id_tid;
            ex_q.opcode <= decode_opcode(id_op_raw);
            ex_q.rd     <= id_rd;
            ex_q.imm    <= id_imm;
            ex_q.data   <= '0;

            mem_q      <= ex_q;
            mem_q.data <= ex_is_inc ? ex_sum : '0;

            wb_q      <= mem_q;
            wb_q.data <= (mem_q.opcode == OP_LW) ? data_mem_rdata : mem_q.data;
        end
    end

    // Register write-back only for valid INC/LW slots; otherwise all zero.
    assign wb_writes        = wb_q.valid && ((wb_q.opcode == OP_INC) || (wb_q.opcode == OP_LW));
    assign reg_access_we    = wb_writes;
    assign reg_access_waddr = wb_writes ? {wb_q.tid, wb_q.rd} : '0;
    assign reg_access_wdata = wb_writes ? wb_q.data : '0;

    // Fields that are carried in the slot struct but not needed at every stage.
    logic unused_bits;
    assign unused_bits = ^{instr_mem_instruction[INSTR_WIDTH-1:IMM_MSB+1],
                           ex_q.data, mem_q.imm, wb_q.imm};

endmodule
`default_nettype wire

// File: tb/tb_risc_processor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_processor
//  Purpose  : Self-checking bench for risc_processor with behavioural BRAMs
//             and a write scoreboard for register and data memory ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_risc_processor;

    import risc_pkg::*;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] instr_mem_pc;
    logic [31:0] instr_mem_instruction;
    logic [7:0]  reg_access_raddr;
    logic [63:0] reg_access_rdata;
    logic [7:0]  reg_access_waddr;
    logic [63:0] reg_access_wdata;
    logic        reg_access_we;
    logic [10:0] data_mem_raddr;
    logic [63:0] data_mem_rdata;
    logic [10:0] data_mem_waddr;
    logic [63:0] data_mem_wdata;
    logic        data_mem_we;

    always #5 clk = ~clk;

    risc_processor dut (
        .clk                   (clk),
        .reset                 (reset),
        .instr_mem_pc          (instr_mem_pc),
        .instr_mem_instruction (instr_mem_instruction),
        .reg_access_raddr      (reg_access_raddr),
        .reg_access_rdata      (reg_access_rdata),
        .reg_access_waddr      (reg_access_waddr),
        .reg_access_wdata      (reg_access_wdata),
        .reg_access_we         (reg_access_we),
        .data_mem_raddr        (data_mem_raddr),
        .data_mem_rdata        (data_mem_rdata),
        .data_mem_waddr        (data_mem_waddr),
        .data_mem_wdata        (data_mem_wdata),
        .data_mem_we           (data_mem_we)
    );

    // Behavioural memories, all written from one process (DUT ports or backdoor).
    logic [31:0] imem [2048];
    logic [63:0] regs [256];
    logic [63:0] dmem [2048];

    logic        bd_en    = 1'b0;
    logic        bd_clear = 1'b0;
    logic [1:0]  bd_mem   = 2'd0;
    logic [10:0] bd_addr  = '0;
    logic [63:0] bd_data  = '0;

    always @(posedge clk) begin
        instr_mem_instruction <= imem[instr_mem_pc];
        reg_access_rdata      <= regs[reg_access_raddr];
        data_mem_rdata        <= dmem[data_mem_raddr];
        if (bd_clear) begin
            for (int i = 0; i < 2048; i++) begin
                imem[i] <= '0;
                dmem[i] <= '0;
            end
            for (int i = 0; i < 256; i++) regs[i] <= '0;
        end else if (bd_en) begin
            case (bd_mem)
                2'd0:    imem[bd_addr] <= bd_data[31:0];
                2'd1:    regs[bd_addr[7:0]] <= bd_data;
                default: dmem[bd_addr] <= bd_data;
            endcase
        end else begin
            if (reg_access_we) regs[reg_access_waddr] <= reg_access_wdata;
            if (data_mem_we)   dmem[data_mem_waddr]   <= data_mem_wdata;
        end
    end

    typedef struct packed {
        logic [10:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t reg_q[$];
    wr_t dm_q[$];
    int  total = 0;
    int  bad   = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [15:0] imm);
        return {5'b0, imm, rd, op};
    endfunction

    task automatic bd_write(input logic [1:0] m, input logic [10:0] a, input logic [63:0] d);
        bd_mem  = m;
        bd_addr = a;
        bd_data = d;
        bd_en   = 1'b1;
        @(posedge clk);
        #1 bd_en = 1'b0;
    endtask

    task automatic begin_test();
        reset = 1'b0;
        reg_q.delete();
        dm_q.delete();
        bd_clear = 1'b1;
        @(posedge clk);
        #1 bd_clear = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Advance to the next falling edge and retire any DUT write against the scoreboard.
    task automatic step();
        wr_t e;
        @(negedge clk);
        if (reg_access_we === 1'b1) begin
            total++;
            if (reg_q.size() == 0) begin
                bad++;
                $display("FAIL reg_write: unexpected addr=%h data=%h, required no write",
                         reg_access_waddr, reg_access_wdata);
            end else begin
                e = reg_q.pop_front();
                if (reg_access_waddr !== e.addr[7:0] || reg_access_wdata !== e.data) begin
                    bad++;
                    $display("FAIL reg_write: got addr=%h data=%h, required addr=%h data=%h",
                             reg_access_waddr, reg_access_wdata, e.addr[7:0], e.data);
                end
            end
        end
        if (data_mem_we === 1'b1) begin
            total++;
            if (dm_q.size() == 0) begin
                bad++;
                $display("FAIL dmem_write: unexpected addr=%h data=%h, required no write",
                         data_mem_waddr, data_mem_wdata);
            end else begin
                e = dm_q.pop_front();
                if (data_mem_waddr !== e.addr || data_mem_wdata !== e.data) begin
                    bad++;
                    $display("FAIL dmem_write: got addr=%h data=%h, required addr=%h data=%h",
                             data_mem_waddr, data_mem_wdata, e.addr, e.data);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0] exp_pc;
        #2 reset = 1'b0;
        begin_test();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (reg_access_we !== 1'b0 || data_mem_we !== 1'b0 || instr_mem_pc !== 11'h0 ||
                reg_access_raddr !== 8'h0 || data_mem_raddr !== 11'h0 ||
                data_mem_waddr !== 11'h0 || reg_access_wdata !== 64'h0) begin
                bad++;
                $display("FAIL reset_outputs: we=%b/%b pc=%h raddr=%h, required all zero",
                         reg_access_we, data_mem_we, instr_mem_pc, reg_access_raddr);
            end
        end
        release_reset();
        for (int i = 0; i < 17; i++) begin
            exp_pc = {3'(i % 8), 8'(i / 8)};
            step();
            total++;
            if (instr_mem_pc !== exp_pc) begin
                bad++;
                $display("FAIL fetch_order[%0d]: got %h, required %h", i, instr_mem_pc, exp_pc);
            end
        end
    endtask

    task automatic test_load_inc_store(input logic [63:0] init);
        begin_test();
        bd_write(2'd0, {3'd0, 8'd0}, {32'h0, enc(OP_LW,  5'd7, 16'd4)});
        bd_write(2'd0, {3'd0, 8'd1}, {32'h0, enc(OP_INC, 5'd7, 16'd1)});
        bd_write(2'd0, {3'd0, 8'd2}, {32'h0, enc(OP_SW,  5'd7, 16'd8)});
        bd_write(2'd2, 11'h004, init);
        reg_q.push_back('{addr: 11'h007, data: init});
        reg_q.push_back('{addr: 11'h007, data: init + 64'd1});
        dm_q.push_back('{addr: 11'h008, data: init + 64'd1});
        release_reset();
        repeat (40) step();
        total++;
        if (reg_q.size() != 0 || dm_q.size() != 0) begin
            bad++;
            $display("FAIL lis_pending: reg=%0d dmem=%0d left, required 0/0",
                     reg_q.size(), dm_q.size());
        end
        total++;
        if (regs[8'h07] !== init + 64'd1) begin
            bad++;
            $display("FAIL lis_reg7: got %h, required %h", regs[8'h07], init + 64'd1);
        end
        total++;
        if (dmem[11'h008] !== init + 64'd1) begin
            bad++;
            $display("FAIL lis_dmem8: got %h, required %h", dmem[11'h008], init + 64'd1);
        end
    endtask

    task automatic test_thread5_inc();
        logic touched;
        begin_test();
        bd_write(2'd0, {3'd5, 8'd0}, {32'h0, enc(OP_INC, 5'd3, 16'hFFFF)});
        bd_write(2'd0, {3'd5, 8'd1}, {32'h0, enc(OP_INC, 5'd3, 16'hFFFF)});
        reg_q.push_back('{addr: 11'h0A3, data: 64'hFFFF});
        reg_q.push_back('{addr: 11'h0A3, data: 64'h1FFFE});
        release_reset();
        repeat (30) step();
        total++;
        if (regs[8'hA3] !== 64'h1FFFE || reg_q.size() != 0) begin
            bad++;
            $display("FAIL t5_inc: got %h (pending %0d), required 1fffe (pending 0)",
                     regs[8'hA3], reg_q.size());
        end
        touched = 1'b0;
        for (int i = 0; i < 32; i++) if (regs[i] !== 64'h0) touched = 1'b1;
        total++;
        if (touched !== 1'b0) begin
            bad++;
            $display("FAIL t5_isolation: thread0 regs modified=%b, required 0", touched);
        end
    endtask

    task automatic test_wrap_and_bad_op();
        begin_test();
        bd_write(2'd1, 11'h022, 64'hFFFF_FFFF_FFFF_FFFF);
        bd_write(2'd0, {3'd1, 8'd0}, {32'h0, enc(OP_INC, 5'd2, 16'd1)});
        bd_write(2'd0, {3'd2, 8'd0}, {32'h0, enc(6'h3F, 5'd4, 16'd5)});
        bd_write(2'd0, {3'd3, 8'd0}, {32'h0, 32'hF800_0000 | enc(6'h3F, 5'd1, 16'h10)});
        reg_q.push_back('{addr: 11'h022, data: 64'h0});
        release_reset();
        repeat (30) step();
        total++;
        if (regs[8'h22] !== 64'h0 || reg_q.size() != 0) begin
            bad++;
            $display("FAIL inc_wrap: got %h (pending %0d), required 0 (pending 0)",
                     regs[8'h22], reg_q.size());
        end
        total++;
        if (regs[8'h44] !== 64'h0 || dmem[11'h205] !== 64'h0) begin
            bad++;
            $display("FAIL bad_opcode: reg44=%h dmem205=%h, required 0/0",
                     regs[8'h44], dmem[11'h205]);
        end
    endtask

    task automatic test_reset_mid_store();
        begin_test();
        bd_write(2'd1, 11'h001, 64'd99);
        bd_write(2'd0, {3'd0, 8'd0}, {32'h0, enc(OP_SW, 5'd1, 16'd3)});
        release_reset();
        step();
        step();
        dm_q.push_back('{addr: 11'h003, data: 64'd99});
        step();
        total++;
        if (data_mem_we !== 1'b1) begin
            bad++;
            $display("FAIL sw_in_ex: data_mem_we=%b, required 1", data_mem_we);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (data_mem_we !== 1'b0 || reg_access_we !== 1'b0 || data_mem_waddr !== 11'h0) begin
            bad++;
            $display("FAIL async_flush: dwe=%b rwe=%b waddr=%h, required 0/0/0",
                     data_mem_we, reg_access_we, data_mem_waddr);
        end
        repeat (3) step();
        total++;
        if (dmem[11'h003] !== 64'h0) begin
            bad++;
            $display("FAIL flushed_store: dmem3=%h, required 0", dmem[11'h003]);
        end
        release_reset();
        dm_q.push_back('{addr: 11'h003, data: 64'd99});
        step();
        total++;
        if (instr_mem_pc !== 11'h000) begin
            bad++;
            $display("FAIL restart_pc0: got %h, required 000", instr_mem_pc);
        end
        step();
        total++;
        if (instr_mem_pc !== 11'h100) begin
            bad++;
            $display("FAIL restart_pc1: got %h, required 100", instr_mem_pc);
        end
        repeat (20) step();
        total++;
        if (dmem[11'h003] !== 64'd99 || dm_q.size() != 0) begin
            bad++;
            $display("FAIL replayed_store: dmem3=%h pending=%0d, required 99/0",
                     dmem[11'h003], dm_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_inc_store(64'd41);
        test_load_inc_store(64'd0);
        test_thread5_inc();
        test_wrap_and_bad_op();
        test_reset_mid_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
